imem_boot_loader: RTL and testbench

//  Instruction-side front end for cpu_part; it sits directly upstream and drives i_datain, start, enable.
//  - Accepts a program over a valid/ready word stream into a 2^ADDR_W x DATA_W instruction RAM.
//  - Pulses start, then serves instructions combinationally from the CPU's i_addr.
//  - Watches fetched words for HALT and parks, ready for a new program.

---
 rtl/imem_boot_loader.sv | 145 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Instruction-side front end for cpu_part: streams a program into a local RAM,
// pulses start, serves fetches combinationally and parks on HALT.
module imem_boot_loader #(
  parameter int               ADDR_W   = 8,
  parameter int               DATA_W   = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h0000,
  parameter logic [4:0]       HALT_OP  = 5'b00001
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_datain,
  output logic              start,
  output logic              enable,
  output logic              running,
  output logic              halted,
  output logic [ADDR_W:0]   word_count
);

  localparam int CW = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BOOT,
    S_RUN,
    S_HALTED
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     word_count_q, word_count_d;
  logic              load_ready_q, load_ready_d;
  logic              start_q, start_d;
  logic              enable_q, enable_d;
  logic              running_q, running_d;
  logic              halted_q, halted_d;

  logic [DATA_W-1:0] ram_q [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              xfer;
  logic              halt_seen;

  assign xfer = load_valid && load_ready_q;

  // Program storage is intentionally left out of reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      ram_q[wr_addr] <= load_data;
    end
  end

  // Fetch path is zero-latency; running_q gates it so every other state sees NOP.
  assign ram_rdata = ram_q[i_addr];
  assign i_datain  = running_q ? ram_rdata : NOP_WORD;
  assign halt_seen = running_q && (i_datain[DATA_W-1 -: 5] == HALT_OP);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    word_count_d = word_count_q;
    wr_en        = 1'b0;
    wr_addr      = wr_ptr_q;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (xfer) begin
          wr_en        = 1'b1;
          wr_addr      = '0;
          wr_ptr_d     = ADDR_W'(1);
          word_count_d = CW'(1);
          state_d      = load_last ? S_BOOT : S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          wr_en        = 1'b1;
          wr_addr      = wr_ptr_q;
          wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
          word_count_d = word_count_q + CW'(1);
          // A full RAM acts as an implicit last word.
          if (load_last || (wr_ptr_q == LAST_ADDR)) begin
            state_d = S_BOOT;
          end
        end
      end
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (halt_seen) begin
          state_d = S_HALTED;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    load_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_HALTED);
    start_d      = (state_d == S_BOOT);
    enable_d     = (state_d == S_BOOT) || (state_d == S_RUN) || (state_d == S_HALTED);
    running_d    = (state_d == S_RUN);
    halted_d     = (state_d == S_HALTED);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      load_ready_q <= 1'b1;
      start_q      <= 1'b0;
      enable_q     <= 1'b0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      word_count_q <= word_count_d;
      load_ready_q <= load_ready_d;
      start_q      <= start_d;
      enable_q     <= enable_d;
      running_q    <= running_d;
      halted_q     <= halted_d;
    end
  end

  assign load_ready = load_ready_q;
  assign start      = start_q;
  assign enable     = enable_q;
  assign running    = running_q;
  assign halted     = halted_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: load, boot, fetch, halt, overflow,
// stalls, ignored words, resets and reloads.
module tb_imem_boot_loader;

  logic        clock;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic [7:0]  i_addr;
  logic [15:0] i_datain;
  logic        start;
  logic        enable;
  logic        running;
  logic        halted;
  logic [8:0]  word_count;

  int checks;
  int errors;

  imem_boot_loader dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .i_addr     (i_addr),
    .i_datain   (i_datain),
    .start      (start),
    .enable     (enable),
    .running    (running),
    .halted     (halted),
    .word_count (word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    @(posedge clock);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    $display("xfer data=%h last=%0b word_count=%0d start=%0b", data, last, word_count, start);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    load_last  = 1'b0;
    i_addr     = 8'd0;

    // 1: asynchronous reset mid-cycle
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_start",      32'(start),      32'd0);
    check("rst_enable",     32'(enable),     32'd0);
    check("rst_running",    32'(running),    32'd0);
    check("rst_halted",     32'(halted),     32'd0);
    check("rst_i_datain",   32'(i_datain),   32'h0000);
    check("rst_word_count", 32'(word_count), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check("rel_load_ready", 32'(load_ready), 32'd1);

    // 2: four-word program
    push(16'h8100, 1'b0);
    check("p4_wc1", 32'(word_count), 32'd1);
    check("p4_start_w1", 32'(start), 32'd0);
    push(16'h8201, 1'b0);
    push(16'h2312, 1'b0);
    check("p4_start_w3", 32'(start), 32'd0);
    check("p4_wc3", 32'(word_count), 32'd3);
    push(16'h0800, 1'b1);
    check("p4_start", 32'(start), 32'd1);
    check("p4_boot_enable", 32'(enable), 32'd1);
    check("p4_boot_ready", 32'(load_ready), 32'd0);
    check("p4_boot_running", 32'(running), 32'd0);
    check("p4_wc4", 32'(word_count), 32'd4);
    tick();
    check("p4_run_start", 32'(start), 32'd0);
    check("p4_run_running", 32'(running), 32'd1);
    check("p4_run_enable", 32'(enable), 32'd1);
    i_addr = 8'd2;
    #1;
    check("p4_fetch_add", 32'(i_datain), 32'h2312);

    // 3: HALT detect
    i_addr = 8'd3;
    #1;
    check("p4_fetch_halt", 32'(i_datain), 32'h0800);
    tick();
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_running", 32'(running), 32'd0);
    check("halt_datain", 32'(i_datain), 32'h0000);
    check("halt_enable", 32'(enable), 32'd1);
    check("halt_ready", 32'(load_ready), 32'd1);

    // 5a: reload from HALTED with stalls between words
    i_addr = 8'd0;
    push(16'h9000, 1'b0);
    check("st_wc1", 32'(word_count), 32'd1);
    tick();
    check("st_stall1_wc", 32'(word_count), 32'd1);
    push(16'h9111, 1'b0);
    tick();
    check("st_stall2_wc", 32'(word_count), 32'd2);
    push(16'h0800, 1'b1);
    check("st_start", 32'(start), 32'd1);
    check("st_wc3", 32'(word_count), 32'd3);
    tick();
    #1;
    check("st_fetch0", 32'(i_datain), 32'h9000);
    i_addr = 8'd1;
    #1;
    check("st_fetch1", 32'(i_datain), 32'h9111);
    i_addr = 8'd2;
    tick();
    check("st_halted", 32'(halted), 32'd1);

    // 4: overflow, 256 words with no load_last
    i_addr = 8'd0;
    for (int i = 0; i < 255; i++) begin
      push(16'h8000 | 16'(i), 1'b0);
    end
    check("ov_wc255", 32'(word_count), 32'd255);
    check("ov_ready255", 32'(load_ready), 32'd1);
    check("ov_start255", 32'(start), 32'd0);
    push(16'h80FF, 1'b0);
    check("ov_start", 32'(start), 32'd1);
    check("ov_wc256", 32'(word_count), 32'd256);
    check("ov_ready", 32'(load_ready), 32'd0);
    tick();
    i_addr = 8'd255;
    #1;
    check("ov_fetch255", 32'(i_datain), 32'h80FF);
    i_addr = 8'd0;
    #1;
    check("ov_fetch0", 32'(i_datain), 32'h8000);

    // 5b: words offered in RUN are ignored
    load_valid = 1'b1;
    load_data  = 16'h0800;
    load_last  = 1'b1;
    tick();
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("ign_running", 32'(running), 32'd1);
    check("ign_wc", 32'(word_count), 32'd256);
    check("ign_ready", 32'(load_ready), 32'd0);
    check("ign_fetch0", 32'(i_datain), 32'h8000);
    i_addr = 8'd1;
    #1;
    check("ign_fetch1", 32'(i_datain), 32'h8001);

    // reset mid-RUN
    reset = 1'b0;
    #1;
    check("rrun_running", 32'(running), 32'd0);
    check("rrun_datain", 32'(i_datain), 32'h0000);
    check("rrun_ready", 32'(load_ready), 32'd1);
    check("rrun_wc", 32'(word_count), 32'd0);
    check("rrun_enable", 32'(enable), 32'd0);
    tick();
    reset = 1'b1;
    i_addr = 8'd0;

    // 6: reset mid-LOAD after 2 of 5 words, then a fresh 3-word load
    push(16'hA000, 1'b0);
    push(16'hA001, 1'b0);
    check("rl_wc2", 32'(word_count), 32'd2);
    reset = 1'b0;
    #1;
    check("rl_wc0", 32'(word_count), 32'd0);
    check("rl_ready", 32'(load_ready), 32'd1);
    check("rl_start", 32'(start), 32'd0);
    tick();
    reset = 1'b1;
    push(16'hB000, 1'b0);
    check("fr_wc1", 32'(word_count), 32'd1);
    push(16'hB001, 1'b0);
    push(16'hB002, 1'b1);
    check("fr_start", 32'(start), 32'd1);
    check("fr_wc3", 32'(word_count), 32'd3);
    tick();
    #1;
    check("fr_fetch0", 32'(i_datain), 32'hB000);
    i_addr = 8'd2;
    #1;
    check("fr_fetch2", 32'(i_datain), 32'hB002);

    // single-word program that is itself a HALT
    reset = 1'b0;
    #1;
    reset = 1'b1;
    i_addr = 8'd0;
    push(16'h0800, 1'b1);
    check("one_start", 32'(start), 32'd1);
    check("one_wc", 32'(word_count), 32'd1);
    tick();
    check("one_fetch", 32'(i_datain), 32'h0800);
    tick();
    check("one_halted", 32'(halted), 32'd1);
    check("one_start_off", 32'(start), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
